// File: rtl/eth_pkg.sv
// Shared definitions for the eth transmit path: arbiter state encoding,
// UDP payload limit and a one-hot decode helper.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SEND      = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    localparam int MAX_UDP_LEN = 1472;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester found scanning upward
// from (last+1) mod N, wrapping around.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        int best;
        valid = 1'b0;
        idx   = '0;
        best  = N;
        // Distance from the slot just after 'last'; the smallest distance wins.
        for (int c = 0; c < N; c++) begin
            if (req[c] && (((c + 2 * N - 1 - int'(last)) % N) < best)) begin
                best  = (c + 2 * N - 1 - int'(last)) % N;
                valid = 1'b1;
                idx   = W'(c);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin scheduler sharing the single eth UDP transmit port among
// NUM_SRC frame sources, with length check, busy timeout and inter-frame gap.
module udp_tx_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int MAX_LEN      = MAX_UDP_LEN,
    parameter int IFG_CYCLES   = 12,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                   gmii_tx_clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [16*NUM_SRC-1:0]  src_len,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_grant,
    output logic [NUM_SRC-1:0]     src_rd,
    output logic [NUM_SRC-1:0]     src_drop,
    output logic                   udp_tx_en,
    output logic [15:0]            udp_tx_data_num,
    output logic [7:0]             udp_tx_data,
    input  logic                   udp_tx_req,
    input  logic                   tx_rdy,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic                   busy
);

    localparam int SEL_W = $clog2(NUM_SRC);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);

    localparam logic [15:0]        MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(IFG_CYCLES - 1);
    localparam logic [NUM_SRC-1:0] ONE       = NUM_SRC'(1);

    tx_state_e          state_q, state_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [NUM_SRC-1:0] drop_q, drop_d;
    logic               err_len_q, err_len_d;
    logic               err_tmo_q, err_tmo_d;

    logic [15:0]        len_arr  [NUM_SRC];
    logic [7:0]         byte_arr [NUM_SRC];
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic [15:0]        pick_len;
    logic               pick_bad;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign len_arr[gi]   = src_len[16*gi +: 16];
            assign byte_arr[gi]  = src_data[8*gi +: 8];
            assign src_grant[gi] = (state_q == ST_START) && (sel_q == SEL_W'(gi));
            // Reads only reach a source while its frame is actually being sent.
            assign src_rd[gi]    = (state_q == ST_SEND) && udp_tx_req && (sel_q == SEL_W'(gi));
        end
    endgenerate

    rr_pick #(
        .N (NUM_SRC),
        .W (SEL_W)
    ) u_rr_pick (
        .req   (src_req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_len = len_arr[pick_idx];
    assign pick_bad = (pick_len == 16'd0) || (pick_len > MAX_LEN_W);

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= SEL_W'(NUM_SRC - 1);
            sel_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            drop_q    <= '0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            drop_q    <= drop_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        drop_d    = '0;
        err_len_d = err_len_q;
        err_tmo_d = err_tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_rdy && pick_valid) begin
                    last_d = pick_idx;
                    // A rejected source loses its turn so the scan moves past it.
                    if (pick_bad) begin
                        drop_d = ONE << pick_idx;
                    end else begin
                        sel_d   = pick_idx;
                        len_d   = pick_len;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_rdy) begin
                    state_d = ST_SEND;
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    gap_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (udp_tx_req && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (tx_rdy) begin
                    if (cnt_q != len_q) begin
                        err_len_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign udp_tx_en       = (state_q == ST_START);
    assign udp_tx_data_num = len_q;
    assign udp_tx_data     = byte_arr[sel_q];
    assign src_drop        = drop_q;
    assign err_len         = err_len_q;
    assign err_timeout     = err_tmo_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: a scripted eth model drives tx_rdy and
// udp_tx_req, and each scenario task checks the arbiter's response inline.
module tb_udp_tx_arbiter;
    import eth_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_req;
    logic [63:0] src_len;
    logic [31:0] src_data;
    logic [3:0]  src_grant;
    logic [3:0]  src_rd;
    logic [3:0]  src_drop;
    logic        udp_tx_en;
    logic [15:0] udp_tx_data_num;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_req;
    logic        tx_rdy;
    logic        err_len;
    logic        err_timeout;
    logic        busy;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    udp_tx_arbiter #(
        .NUM_SRC      (4),
        .MAX_LEN      (1472),
        .IFG_CYCLES   (12),
        .BUSY_TIMEOUT (64)
    ) dut (
        .gmii_tx_clk     (clk),
        .rst             (rst),
        .src_req         (src_req),
        .src_len         (src_len),
        .src_data        (src_data),
        .src_grant       (src_grant),
        .src_rd          (src_rd),
        .src_drop        (src_drop),
        .udp_tx_en       (udp_tx_en),
        .udp_tx_data_num (udp_tx_data_num),
        .udp_tx_data     (udp_tx_data),
        .udp_tx_req      (udp_tx_req),
        .tx_rdy          (tx_rdy),
        .err_len         (err_len),
        .err_timeout     (err_timeout),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        src_req    = '0;
        udp_tx_req = 1'b0;
        tx_rdy     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Scripted eth: waits for a start pulse, drops tx_rdy, strobes nstrobe bytes, raises tx_rdy.
    task automatic run_frame(input int nstrobe, input bit clr_req, output bit started,
                             output int gidx, output int scyc, output int rd_cnt);
        int w;
        started = 1'b0;
        gidx    = 0;
        scyc    = 0;
        rd_cnt  = 0;
        w       = 0;
        while (!udp_tx_en && w < 300) begin
            tick();
            w++;
        end
        if (udp_tx_en) begin
            started = 1'b1;
            gidx    = int'(onehot_to_idx({4'b0000, src_grant}));
            scyc    = cyc;
            $display("frame start src=%0d len=%0d cycle=%0d strobes=%0d", gidx, udp_tx_data_num, scyc, nstrobe);
            if (clr_req) src_req[2'(gidx)] = 1'b0;
            tick();
            tx_rdy = 1'b0;
            tick();
            for (int b = 0; b < nstrobe; b++) begin
                udp_tx_req = 1'b1;
                #1;
                if (src_rd[2'(gidx)]) rd_cnt++;
                tick();
            end
            udp_tx_req = 1'b0;
            tx_rdy     = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        src_req    = '0;
        src_len    = '0;
        src_data   = 32'h44332211;
        udp_tx_req = 1'b1;
        tx_rdy     = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (udp_tx_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got=%b exp=0", udp_tx_en); end
        n_cmp++; if (src_grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b exp=0000", src_grant); end
        n_cmp++; if (src_rd !== 4'b0000) begin n_bad++; $display("FAIL reset_rd got=%b exp=0000", src_rd); end
        n_cmp++; if (src_drop !== 4'b0000) begin n_bad++; $display("FAIL reset_drop got=%b exp=0000", src_drop); end
        n_cmp++; if (udp_tx_data_num !== 16'd0) begin n_bad++; $display("FAIL reset_num got=%0d exp=0", udp_tx_data_num); end
        n_cmp++; if (udp_tx_data !== 8'h11) begin n_bad++; $display("FAIL reset_data got=%h exp=11", udp_tx_data); end
        n_cmp++; if ({err_len, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b exp=00", {err_len, err_timeout}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (src_rd !== 4'b0000) begin n_bad++; $display("FAIL idle_req_rd got=%b exp=0000", src_rd); end
        udp_tx_req = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_single();
        int rd_cnt;
        int n;
        logic [7:0] exp_b;
        rd_cnt = 0;
        src_len[15:0] = 16'd16;
        src_req = 4'b0001;
        #1;
        n_cmp++; if (udp_tx_en !== 1'b0) begin n_bad++; $display("FAIL single_en_early got=%b exp=0", udp_tx_en); end
        tick();
        n_cmp++; if (udp_tx_en !== 1'b1) begin n_bad++; $display("FAIL single_en got=%b exp=1", udp_tx_en); end
        n_cmp++; if (src_grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b exp=0001", src_grant); end
        n_cmp++; if (udp_tx_data_num !== 16'd16) begin n_bad++; $display("FAIL single_num got=%0d exp=16", udp_tx_data_num); end
        src_req = 4'b0000;
        tick();
        n_cmp++; if ({udp_tx_en, src_grant} !== 5'b0) begin n_bad++; $display("FAIL single_pulse got=%b exp=00000", {udp_tx_en, src_grant}); end
        tx_rdy     = 1'b0;
        udp_tx_req = 1'b1;
        #1;
        n_cmp++; if (src_rd !== 4'b0000) begin n_bad++; $display("FAIL single_wait_rd got=%b exp=0000", src_rd); end
        tick();
        for (int b = 0; b < 16; b++) begin
            udp_tx_req = 1'b1;
            #1;
            if (src_rd === 4'b0001) rd_cnt++;
            tick();
            exp_b = 8'hA0 + 8'(b);
            src_data[7:0] = exp_b;
            #1;
            n_cmp++; if (udp_tx_data !== exp_b) begin n_bad++; $display("FAIL single_byte%0d got=%h exp=%h", b, udp_tx_data, exp_b); end
        end
        udp_tx_req = 1'b0;
        tx_rdy     = 1'b1;
        tick();
        n_cmp++; if (rd_cnt !== 16) begin n_bad++; $display("FAIL single_rd_count got=%0d exp=16", rd_cnt); end
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL single_err_len got=%b exp=0", err_len); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
        wait_idle(n);
        n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL single_gap_len got=%0d exp=12", n); end
        $display("single frame done rd=%0d gap=%0d", rd_cnt, n);
    endtask

    task automatic test_fairness();
        bit st;
        int g, sc, rc, prev, n;
        do_reset();
        src_len = {16'd8, 16'd8, 16'd8, 16'd8};
        src_req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            run_frame(8, 1'b0, st, g, sc, rc);
            n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL fair_start%0d got=%b exp=1", k, st); end
            n_cmp++; if (g !== k % 4) begin n_bad++; $display("FAIL fair_order%0d got=%0d exp=%0d", k, g, k % 4); end
            n_cmp++; if (rc !== 8) begin n_bad++; $display("FAIL fair_rd%0d got=%0d exp=8", k, rc); end
            n_cmp++; if (udp_tx_data_num !== 16'd8) begin n_bad++; $display("FAIL fair_num%0d got=%0d exp=8", k, udp_tx_data_num); end
            if (k > 0) begin
                n_cmp++; if (sc - prev !== 24) begin n_bad++; $display("FAIL fair_spacing%0d got=%0d exp=24", k, sc - prev); end
            end
            prev = sc;
        end
        src_req = 4'b0000;
        wait_idle(n);
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL fair_err_len got=%b exp=0", err_len); end
    endtask

    task automatic test_bad_len();
        bit st;
        int g, sc, rc, n;
        do_reset();
        src_len = {16'd4, 16'd1473, 16'd0, 16'd0};
        src_req = 4'b1110;
        tick();
        n_cmp++; if (src_drop !== 4'b0010) begin n_bad++; $display("FAIL bad_drop1 got=%b exp=0010", src_drop); end
        n_cmp++; if (udp_tx_en !== 1'b0) begin n_bad++; $display("FAIL bad_en1 got=%b exp=0", udp_tx_en); end
        src_req[1] = 1'b0;
        tick();
        n_cmp++; if (src_drop !== 4'b0100) begin n_bad++; $display("FAIL bad_drop2 got=%b exp=0100", src_drop); end
        n_cmp++; if (udp_tx_en !== 1'b0) begin n_bad++; $display("FAIL bad_en2 got=%b exp=0", udp_tx_en); end
        src_req[2] = 1'b0;
        tick();
        n_cmp++; if (src_drop !== 4'b0000) begin n_bad++; $display("FAIL bad_drop3 got=%b exp=0000", src_drop); end
        n_cmp++; if (src_grant !== 4'b1000) begin n_bad++; $display("FAIL bad_grant3 got=%b exp=1000", src_grant); end
        n_cmp++; if (udp_tx_data_num !== 16'd4) begin n_bad++; $display("FAIL bad_num3 got=%0d exp=4", udp_tx_data_num); end
        run_frame(4, 1'b1, st, g, sc, rc);
        n_cmp++; if (g !== 3 || rc !== 4) begin n_bad++; $display("FAIL bad_frame3 got=src%0d/rd%0d exp=src3/rd4", g, rc); end
        wait_idle(n);
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL bad_err_len got=%b exp=0", err_len); end
    endtask

    task automatic test_len_mismatch();
        bit st;
        int g, sc, rc, n;
        do_reset();
        src_len = {16'd0, 16'd0, 16'd3, 16'd10};
        src_req = 4'b0001;
        run_frame(9, 1'b1, st, g, sc, rc);
        n_cmp++; if (st !== 1'b1 || g !== 0) begin n_bad++; $display("FAIL mis_start got=%b/src%0d exp=1/src0", st, g); end
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL mis_err_len got=%b exp=1", err_len); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL mis_err_tmo got=%b exp=0", err_timeout); end
        wait_idle(n);
        src_req = 4'b0010;
        run_frame(3, 1'b1, st, g, sc, rc);
        n_cmp++; if (st !== 1'b1 || g !== 1 || rc !== 3) begin n_bad++; $display("FAIL mis_next got=%b/src%0d/rd%0d exp=1/src1/rd3", st, g, rc); end
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL mis_sticky got=%b exp=1", err_len); end
        wait_idle(n);
    endtask

    task automatic test_stuck_mac();
        int w, n;
        do_reset();
        src_len[15:0] = 16'd5;
        src_req = 4'b0001;
        w = 0;
        while (!udp_tx_en && w < 50) begin
            tick();
            w++;
        end
        n_cmp++; if (udp_tx_en !== 1'b1) begin n_bad++; $display("FAIL stuck_start got=%b exp=1", udp_tx_en); end
        src_req = 4'b0000;
        n = 0;
        while (!err_timeout && n < 200) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 65) begin n_bad++; $display("FAIL stuck_tmo_cycles got=%0d exp=65", n); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stuck_gap_busy got=%b exp=1", busy); end
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL stuck_err_len got=%b exp=0", err_len); end
        wait_idle(n);
        n_cmp++; if (n !== 12 || busy !== 1'b0) begin n_bad++; $display("FAIL stuck_to_idle got=%0d/%b exp=12/0", n, busy); end
        $display("stuck mac timeout flagged");
    endtask

    task automatic test_reset_mid();
        bit st;
        int w, g, sc, rc, n;
        do_reset();
        src_len = {16'd0, 16'd8, 16'd0, 16'd4};
        src_req = 4'b0100;
        w = 0;
        while (!udp_tx_en && w < 50) begin
            tick();
            w++;
        end
        n_cmp++; if (src_grant !== 4'b0100) begin n_bad++; $display("FAIL mid_grant got=%b exp=0100", src_grant); end
        src_req = 4'b0000;
        tick();
        tx_rdy = 1'b0;
        tick();
        for (int b = 0; b < 5; b++) begin
            udp_tx_req = 1'b1;
            tick();
        end
        #1;
        n_cmp++; if (src_rd !== 4'b0100) begin n_bad++; $display("FAIL mid_rd_before got=%b exp=0100", src_rd); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, udp_tx_en} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_busy_en got=%b exp=00", {busy, udp_tx_en}); end
        n_cmp++; if (src_rd !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_rd got=%b exp=0000", src_rd); end
        n_cmp++; if (udp_tx_data_num !== 16'd0) begin n_bad++; $display("FAIL mid_rst_num got=%0d exp=0", udp_tx_data_num); end
        udp_tx_req = 1'b0;
        tx_rdy     = 1'b1;
        src_req    = 4'b0101;
        tick();
        rst = 1'b0;
        run_frame(4, 1'b1, st, g, sc, rc);
        n_cmp++; if (st !== 1'b1 || g !== 0 || rc !== 4) begin n_bad++; $display("FAIL mid_after got=%b/src%0d/rd%0d exp=1/src0/rd4", st, g, rc); end
        src_req = 4'b0000;
        wait_idle(n);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_bad_len();
        test_len_mismatch();
        test_stuck_mac();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
